// File: rtl/dec_gpr_wb_arb.sv
// Writeback arbiter for the three GPR write ports plus a pending-producer
// scoreboard used by decode for read-after-write hazard stalls.
module dec_gpr_wb_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SRC-1:0]                   src_valid,
    input  logic [NUM_SRC-1:0][4:0]              src_addr,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   src_data,
    output logic [NUM_SRC-1:0]                   src_ready,
    input  logic                                 alloc_v,
    input  logic [4:0]                           alloc_addr,
    output logic [31:1]                          pend,
    output logic                                 we0,
    output logic                                 we1,
    output logic                                 we2,
    output logic [4:0]                           waddr0,
    output logic [4:0]                           waddr1,
    output logic [4:0]                           waddr2,
    output logic [DATA_WIDTH-1:0]                wd0,
    output logic [DATA_WIDTH-1:0]                wd1,
    output logic [DATA_WIDTH-1:0]                wd2
);

    logic [1:0]                  rr_q, rr_d;
    logic [2:0]                  we_q, we_d;
    logic [2:0][4:0]             waddr_q, waddr_d;
    logic [2:0][DATA_WIDTH-1:0]  wd_q, wd_d;
    logic [31:1]                 pend_q, pend_d;

    logic [1:0] n_grant;
    logic [1:0] idx;
    logic       conflict;
    logic       denied;
    logic       clr_v;

    // Walk sources in rotating priority; each grant claims the next free port.
    always_comb begin
        src_ready = '0;
        we_d      = '0;
        waddr_d   = waddr_q;
        wd_d      = wd_q;
        n_grant   = 2'd0;
        denied    = 1'b0;
        idx       = '0;
        conflict  = 1'b0;
        for (int unsigned p = 0; p < 4; p++) begin
            idx      = rr_q + 2'(p);
            conflict = 1'b0;
            for (int unsigned j = 0; j < 3; j++) begin
                if (we_d[j] && waddr_d[j] == src_addr[idx]) begin
                    conflict = 1'b1;
                end
            end
            if (!rst && src_valid[idx]) begin
                if (src_addr[idx] == 5'd0) begin
                    src_ready[idx] = 1'b1;
                end else if (n_grant != 2'd3 && !conflict) begin
                    src_ready[idx]   = 1'b1;
                    we_d[n_grant]    = 1'b1;
                    waddr_d[n_grant] = src_addr[idx];
                    wd_d[n_grant]    = src_data[idx];
                    n_grant          = n_grant + 2'd1;
                end else begin
                    denied = 1'b1;
                end
            end
        end
        rr_d = denied ? rr_q + 2'd1 : rr_q;
    end

    // A same-cycle allocation outranks the writeback clear of the older producer.
    always_comb begin
        pend_d = '0;
        clr_v  = 1'b0;
        for (int unsigned i = 1; i < 32; i++) begin
            clr_v = 1'b0;
            for (int unsigned j = 0; j < 3; j++) begin
                if (we_d[j] && waddr_d[j] == 5'(i)) begin
                    clr_v = 1'b1;
                end
            end
            pend_d[i] = (alloc_v && alloc_addr == 5'(i)) || (pend_q[i] && !clr_v);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            we_q    <= '0;
            waddr_q <= '0;
            wd_q    <= '0;
            pend_q  <= '0;
        end else begin
            rr_q    <= rr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wd_q    <= wd_d;
            pend_q  <= pend_d;
        end
    end

    assign pend   = pend_q;
    assign we0    = we_q[0];
    assign we1    = we_q[1];
    assign we2    = we_q[2];
    assign waddr0 = waddr_q[0];
    assign waddr1 = waddr_q[1];
    assign waddr2 = waddr_q[2];
    assign wd0    = wd_q[0];
    assign wd1    = wd_q[1];
    assign wd2    = wd_q[2];

endmodule

// File: tb/tb_dec_gpr_wb_arb.sv
// Directed bench for dec_gpr_wb_arb with a per-cycle behavioural reference model.
module tb_dec_gpr_wb_arb;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         src_valid;
    logic [3:0][4:0]    src_addr;
    logic [3:0][DW-1:0] src_data;
    logic [3:0]         src_ready;
    logic               alloc_v;
    logic [4:0]         alloc_addr;
    logic [31:1]        pend;
    logic               we0, we1, we2;
    logic [4:0]         waddr0, waddr1, waddr2;
    logic [DW-1:0]      wd0, wd1, wd2;

    int total = 0;
    int bad   = 0;

    dec_gpr_wb_arb #(.DATA_WIDTH(DW), .NUM_SRC(4)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_addr(src_addr), .src_data(src_data),
        .src_ready(src_ready),
        .alloc_v(alloc_v), .alloc_addr(alloc_addr),
        .pend(pend),
        .we0(we0), .we1(we1), .we2(we2),
        .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
        .wd0(wd0), .wd1(wd1), .wd2(wd2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: state mirrors what the DUT shows after the next edge.
    bit          m_init = 1'b0;
    int          m_rr;
    logic [2:0]  m_we;
    logic [4:0]  m_waddr [3];
    logic [31:0] m_wd    [3];
    logic [31:1] m_pend;

    always @(negedge clk) begin : model
        int         taken[$];
        logic [3:0] exp_rdy;
        bit         denied;
        bit         dup;
        int         k;
        if (rst) begin
            chk("ready_in_rst", src_ready, 4'h0);
            m_init = 1'b1;
            m_rr   = 0;
            m_we   = '0;
            m_pend = '0;
        end else if (m_init) begin
            chk("m_we0", we0, m_we[0]);
            chk("m_we1", we1, m_we[1]);
            chk("m_we2", we2, m_we[2]);
            if (m_we[0]) begin chk("m_waddr0", waddr0, m_waddr[0]); chk("m_wd0", wd0, m_wd[0]); end
            if (m_we[1]) begin chk("m_waddr1", waddr1, m_waddr[1]); chk("m_wd1", wd1, m_wd[1]); end
            if (m_we[2]) begin chk("m_waddr2", waddr2, m_waddr[2]); chk("m_wd2", wd2, m_wd[2]); end
            chk("m_pend", pend, m_pend);

            taken.delete();
            exp_rdy = '0;
            denied  = 1'b0;
            for (int p = 0; p < 4; p++) begin
                k = (m_rr + p) % 4;
                if (src_valid[k]) begin
                    if (src_addr[k] == 5'd0) begin
                        exp_rdy[k] = 1'b1;
                    end else begin
                        dup = 1'b0;
                        foreach (taken[t]) if (taken[t] == int'(src_addr[k])) dup = 1'b1;
                        if (taken.size() < 3 && !dup) begin
                            exp_rdy[k] = 1'b1;
                            m_waddr[taken.size()] = src_addr[k];
                            m_wd[taken.size()]    = src_data[k];
                            taken.push_back(int'(src_addr[k]));
                        end else begin
                            denied = 1'b1;
                        end
                    end
                end
            end
            chk("m_ready", src_ready, exp_rdy);

            m_we = '0;
            for (int i = 0; i < taken.size(); i++) m_we[i] = 1'b1;
            foreach (taken[t]) m_pend[taken[t]] = 1'b0;
            if (alloc_v && alloc_addr != 5'd0) m_pend[alloc_addr] = 1'b1;
            if (denied) m_rr = (m_rr + 1) % 4;
        end
    end

    logic [3:0] g [8];
    logic [3:0] win;

    initial begin
        rst        = 1'b1;
        alloc_v    = 1'b0;
        alloc_addr = '0;
        src_valid  = 4'hF;
        src_addr   = {5'd4, 5'd3, 5'd2, 5'd1};
        src_data   = '0;

        // reset held two cycles with all sources valid
        tick(); #1 chk("rst_ready_a", src_ready, 4'h0);
        tick(); #1 chk("rst_ready_b", src_ready, 4'h0);
        rst = 1'b0;
        src_valid = 4'h0;
        tick();
        chk("rst_we", {we2, we1, we0}, 3'b000);
        chk("rst_pend", pend, 31'd0);

        // four distinct targets, rr=0
        src_valid = 4'hF;
        src_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
        src_data  = {32'h104, 32'h103, 32'h102, 32'h101};
        #1 chk("four_ready", src_ready, 4'b0111);
        tick();
        chk("four_we", {we2, we1, we0}, 3'b111);
        chk("four_waddr", {waddr2, waddr1, waddr0}, {5'd3, 5'd2, 5'd1});
        chk("four_wd", {wd1, wd0}, {32'h102, 32'h101});
        chk("four_wd2", wd2, 32'h103);
        src_valid = 4'b1000;
        #1 chk("four_ready2", src_ready, 4'b1000);
        tick();
        chk("four_we_b", {we2, we1, we0}, 3'b001);
        chk("four_waddr_b", waddr0, 5'd4);
        chk("four_wd_b", wd0, 32'h104);
        src_valid = 4'h0;

        // reset again so rr=0, then same-address collision
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src_valid = 4'b0101;
        src_addr  = {5'd0, 5'd5, 5'd0, 5'd5};
        src_data  = {32'h0, 32'hB, 32'h0, 32'hA};
        #1 chk("dup_ready", src_ready, 4'b0001);
        tick();
        chk("dup_we", {we2, we1, we0}, 3'b001);
        chk("dup_waddr", waddr0, 5'd5);
        chk("dup_wd", wd0, 32'hA);
        src_valid = 4'b0100;
        #1 chk("dup_ready2", src_ready, 4'b0100);
        tick();
        chk("dup_we2", {we2, we1, we0}, 3'b001);
        chk("dup_wd2", wd0, 32'hB);
        src_valid = 4'h0;

        // addr-0 result alongside three real writes (rr=1 now)
        src_valid = 4'hF;
        src_addr  = {5'd8, 5'd7, 5'd0, 5'd6};
        src_data  = {32'h800, 32'h700, 32'h55, 32'h600};
        #1 chk("zero_ready", src_ready, 4'hF);
        tick();
        chk("zero_we", {we2, we1, we0}, 3'b111);
        chk("zero_waddr", {waddr2, waddr1, waddr0}, {5'd6, 5'd8, 5'd7});
        chk("zero_wd0", wd0, 32'h700);
        chk("zero_wd2", wd2, 32'h600);
        src_valid = 4'h0;

        // scoreboard set / clear
        alloc_v    = 1'b1;
        alloc_addr = 5'd9;
        tick();
        alloc_v = 1'b0;
        chk("pend_rise", pend[9], 1'b1);
        tick();
        tick();
        src_valid = 4'b0001;
        src_addr  = {5'd0, 5'd0, 5'd0, 5'd9};
        src_data  = {32'h0, 32'h0, 32'h0, 32'h99};
        #1 chk("pend_wb_ready", src_ready, 4'b0001);
        chk("pend_hold", pend[9], 1'b1);
        tick();
        src_valid = 4'h0;
        chk("pend_wb_we", {we0, waddr0}, {1'b1, 5'd9});
        chk("pend_fall", pend[9], 1'b0);

        alloc_v = 1'b1;
        alloc_addr = 5'd9;
        tick();
        src_valid = 4'b0001;
        src_data  = {32'h0, 32'h0, 32'h0, 32'h98};
        tick();
        alloc_v   = 1'b0;
        src_valid = 4'h0;
        chk("pend_set_wins", pend[9], 1'b1);
        chk("pend_set_wins_we", {we0, waddr0}, {1'b1, 5'd9});
        alloc_v    = 1'b1;
        alloc_addr = 5'd0;
        src_valid  = 4'b0001;
        src_data   = {32'h0, 32'h0, 32'h0, 32'h97};
        tick();
        alloc_v   = 1'b0;
        src_valid = 4'h0;
        chk("pend_all_clear", pend, 31'd0);

        // starvation: four distinct targets held valid for 8 cycles
        src_valid = 4'hF;
        src_addr  = {5'd13, 5'd12, 5'd11, 5'd10};
        src_data  = {32'hD, 32'hC, 32'hB, 32'hA};
        for (int c = 0; c < 8; c++) begin
            #1 g[c] = src_ready & src_valid;
            tick();
        end
        src_valid = 4'h0;
        for (int c = 0; c < 5; c++) begin
            win = g[c] | g[c+1] | g[c+2] | g[c+3];
            chk("starve_window", win, 4'hF);
        end
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dec_gpr_wb_arb.md
# dec_gpr_wb_arb

Writeback arbiter and pending-register scoreboard feeding the three GPR write ports (we0..2 / waddr0..2 / wd0..2) of the general-purpose register file. It accepts results from four execution sources over valid/ready handshakes and grants up to three results per cycle with rotating priority. It never issues two writes to the same register in one cycle. It also tracks which registers have an outstanding producer so that decode can stall on read-after-write hazards.

## Interface
- DATA_WIDTH, 32, result/write data width
- NUM_SRC, 4, number of result sources (fixed at 4; indices 0..3)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- src_valid  input  [NUM_SRC-1:0]  source k presents a result
- src_addr  input  [NUM_SRC-1:0][4:0]  destination GPR of source k
- src_data  input  [NUM_SRC-1:0][DATA_WIDTH-1:0]  result data of source k
- src_ready  output  [NUM_SRC-1:0]  combinational grant; result k consumed when src_valid[k] & src_ready[k]
- alloc_v  input  1  decode allocates a new in-flight producer
- alloc_addr  input  5  destination of the allocated producer
- pend  output  [31:1]  bit i = GPR i has an outstanding producer
- we0/we1/we2  output  1  registered write enables to GPR file
- waddr0/waddr1/waddr2  output  5  registered write addresses
- wd0/wd1/wd2  output  DATA_WIDTH  registered write data

## Operation
- Priority order per cycle: rr, rr+1, rr+2, rr+3 (mod 4). rr is a 2-bit rotating pointer.
- Source with src_addr==0: src_ready=1 whenever valid. No port is consumed, no write is issued, pend is unaffected.
- Nonzero sources are walked in priority order. Source k is granted iff both hold:
  - fewer than 3 ports are already granted this cycle;
  - no earlier-granted source this cycle has the same src_addr.
- A denied source keeps src_ready=0 and must hold valid/addr/data stable (sources' obligation).
- Port fill: the first granted nonzero source goes to port 0, the second to port 1, the third to port 2. Unused ports have we=0 next cycle.
- rr update: if any valid nonzero source was denied this cycle, rr <= rr+1. Otherwise rr holds. Consequence: any waiting source reaches first priority within 4 cycles and is then always granted.
- src_ready is independent of src_data. The source at priority 0 is granted whenever it is valid.
- Scoreboard, evaluated per bit i in 1..31:
  - set_i = alloc_v & alloc_addr==i
  - clr_i = some port granted with address i this cycle
  - next pend[i] = set_i | (pend[i] & ~clr_i). Set wins over a same-cycle clear, because the new producer supersedes the old one.
- alloc_addr==0 is ignored.
- Reset (rst=1 at an edge): we0..2=0, waddr0..2=0, wd0..2=0, pend=0, rr=0.
- While rst is high, src_ready is forced to 0. Results offered during reset are not consumed.
- Multiple outstanding producers to one register are not tracked. The first writeback clears the bit, and issue logic enforces in-order WAW per register.

## Timing
- Handshake at cycle t: the registered write appears on weN/waddrN/wdN during cycle t+1. The GPR file commits it at the end of t+1.
- Latency source→write port: 1 cycle. pend clears at the same edge that registers the write, so the bit is low during t+1.
- Throughput: 3 nonzero writes/cycle plus any number of addr-0 results.
- src_ready is purely combinational from src_valid, src_addr, rr and rst. There is no path from src_ready back into src_valid.
- Output registers load every cycle. A port that received no grant loads we=0; its waddr/wd may keep old values.

## Test plan
- Reset: assert rst 2 cycles with all src_valid=1 → src_ready=0. After release, we0..2=0, pend=0, rr=0.
- Four sources valid with addrs 1,2,3,4 and rr=0 → src_ready=0111. Next cycle: waddr0/1/2=1/2/3 with we=111. rr becomes 1. Cycle after: source 3 granted alone on port 0 (waddr0=4).
- Sources 0 and 2 both target addr 5 (data 0xA, 0xB), rr=0 → only source 0 ready. Next cycle: we0=1, waddr0=5, wd0=0xA, we1=0. The following cycle writes 0xB.
- Source 1 addr 0 and sources 0,2,3 to addrs 6,7,8 → all four src_ready=1. Three writes issued; nothing issued for addr 0.
- alloc_v with alloc_addr=9, then source writes 9 three cycles later → pend[9] rises the next cycle and falls one cycle after the handshake. A same-cycle alloc of 9 and grant of 9 leaves pend[9]=1.
- Starvation: sources 0..3 continuously valid with distinct addrs for 8 cycles → each source granted at least once in every 4 consecutive cycles.
